// File: rtl/pattern_ser_pkg.sv
// Shared types and defaults for the pattern serializer.
// The state enum includes StPar, which is only reached when SER_PARITY_EN is defined.
package pattern_ser_pkg;

    typedef enum logic [1:0] {StIdle, StRun, StPar} ser_state_e;

    localparam int unsigned DefWordW = 8;
    localparam int unsigned DefDepth = 16;

    // Bit counter must hold values 0..word_w inclusive.
    function automatic int unsigned bit_cnt_width(input int unsigned word_w);
        return $clog2(word_w + 1);
    endfunction

endpackage

// File: rtl/pattern_mem.sv
// DEPTH x WORD_W pattern register file: one synchronous write port, one combinational read port.
// Contents are deliberately not reset; out-of-range writes are dropped.
module pattern_mem #(
    parameter int unsigned WORD_W = 8,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WORD_W-1:0] rd_data
);

    logic [WORD_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en && (int'(wr_addr) < int'(DEPTH))) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data = '0;
        if (int'(rd_addr) < int'(DEPTH)) begin
            rd_data = mem_q[rd_addr];
        end
    end

endmodule

// File: rtl/pattern_serializer.sv
// Streams words from an internal pattern memory one bit per clock, one-shot or looped.
// Define SER_PARITY_EN to append an even-parity bit to every word (word period WORD_W+1).
module pattern_serializer
    import pattern_ser_pkg::*;
#(
    parameter int unsigned WORD_W = DefWordW,
    parameter int unsigned DEPTH  = DefDepth,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              clear_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              start,
    input  logic              stop,
    input  logic              loop,
    input  logic              msb_first,
    input  logic [ADDR_W-1:0] last_addr,
    output logic              sout,
    output logic              valid,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] cur_addr
);

    localparam int unsigned CntW = bit_cnt_width(WORD_W);

    ser_state_e        state_q, state_d;
    logic              sout_q, sout_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic              loop_q, loop_d;
    logic              msb_q, msb_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic              stop_q, stop_d;
`ifdef SER_PARITY_EN
    logic              par_q, par_d;
`endif

    logic [ADDR_W-1:0] rd_addr;
    logic [WORD_W-1:0] rd_data;
    logic [ADDR_W-1:0] next_addr;
    logic [ADDR_W-1:0] last_clamped;
    logic              load;
    logic              word_end;
    logic              stop_any;

    pattern_mem #(
        .WORD_W (WORD_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign last_clamped = (int'(last_addr) > int'(DEPTH) - 1) ? ADDR_W'(DEPTH - 1) : last_addr;

    always_comb begin
        state_d    = state_q;
        sout_d     = sout_q;
        valid_d    = valid_q;
        done_d     = 1'b0;
        cur_addr_d = cur_addr_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        loop_d     = loop_q;
        msb_d      = msb_q;
        last_d     = last_q;
        stop_d     = stop_q;
`ifdef SER_PARITY_EN
        par_d      = par_q;
`endif
        load       = 1'b0;
        word_end   = 1'b0;
        rd_addr    = '0;
        next_addr  = (cur_addr_q == last_q) ? '0 : cur_addr_q + ADDR_W'(1);
        // A stop seen on the final edge of a word still ends that word.
        stop_any   = stop_q | stop;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d    = StRun;
                    load       = 1'b1;
                    cur_addr_d = '0;
                    loop_d     = loop;
                    msb_d      = msb_first;
                    last_d     = last_clamped;
                    stop_d     = 1'b0;
                end
            end
            StRun: begin
                stop_d = stop_any;
                if (bit_cnt_q != CntW'(WORD_W)) begin
                    sout_d    = msb_q ? shift_q[WORD_W-1] : shift_q[0];
                    shift_d   = msb_q ? (shift_q << 1) : (shift_q >> 1);
                    bit_cnt_d = bit_cnt_q + CntW'(1);
                end else begin
`ifdef SER_PARITY_EN
                    state_d = StPar;
                    sout_d  = par_q;
`else
                    word_end = 1'b1;
`endif
                end
            end
`ifdef SER_PARITY_EN
            StPar: begin
                stop_d   = stop_any;
                word_end = 1'b1;
            end
`endif
            default: state_d = StIdle;
        endcase

        if (word_end) begin
            if (stop_any || ((cur_addr_q == last_q) && !loop_q)) begin
                state_d   = StIdle;
                sout_d    = 1'b0;
                valid_d   = 1'b0;
                done_d    = 1'b1;
                bit_cnt_d = '0;
                shift_d   = '0;
                stop_d    = 1'b0;
            end else begin
                state_d    = StRun;
                load       = 1'b1;
                cur_addr_d = next_addr;
                rd_addr    = next_addr;
            end
        end

        // Word load registers its first bit immediately, so there is no bubble.
        if (load) begin
            sout_d    = msb_d ? rd_data[WORD_W-1] : rd_data[0];
            shift_d   = msb_d ? (rd_data << 1) : (rd_data >> 1);
            bit_cnt_d = CntW'(1);
            valid_d   = 1'b1;
`ifdef SER_PARITY_EN
            par_d     = ^rd_data;
`endif
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q    <= StIdle;
            sout_q     <= 1'b0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
            cur_addr_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            loop_q     <= 1'b0;
            msb_q      <= 1'b0;
            last_q     <= '0;
            stop_q     <= 1'b0;
`ifdef SER_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            sout_q     <= sout_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
            cur_addr_q <= cur_addr_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            loop_q     <= loop_d;
            msb_q      <= msb_d;
            last_q     <= last_d;
            stop_q     <= stop_d;
`ifdef SER_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

    assign sout     = sout_q;
    assign valid    = valid_q;
    assign busy     = (state_q != StIdle);
    assign done     = done_q;
    assign cur_addr = cur_addr_q;

endmodule

// File: tb/tb_pattern_serializer.sv
// Self-checking bench for pattern_serializer against a per-cycle word/bit-position reference model.
module tb_pattern_serializer;

    localparam int W = 8;
    localparam int D = 16;
`ifdef SER_PARITY_EN
    localparam int Period = W + 1;
`else
    localparam int Period = W;
`endif

    logic       clk = 1'b0;
    logic       clear_n;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       start, stop, loop, msb_first;
    logic [3:0] last_addr;
    logic       sout, valid, busy, done;
    logic [3:0] cur_addr;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: word being played, bit position inside its frame, playback settings.
    logic [7:0] m_mem [D];
    logic [7:0] m_word;
    int         m_pos;
    int         m_addr;
    int         m_last;
    logic       m_busy, m_done, m_loop, m_msb, m_stop;

    always #5 clk = ~clk;

    pattern_serializer u_dut (
        .clk       (clk),
        .clear_n   (clear_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .start     (start),
        .stop      (stop),
        .loop      (loop),
        .msb_first (msb_first),
        .last_addr (last_addr),
        .sout      (sout),
        .valid     (valid),
        .busy      (busy),
        .done      (done),
        .cur_addr  (cur_addr)
    );

    function automatic logic [7:0] exp_vec();
        logic b;
        b = 1'b0;
        if (m_busy) begin
            if (m_pos < W) b = m_msb ? m_word[W-1-m_pos] : m_word[m_pos];
            else           b = ^m_word;
        end
        return {b, m_busy, m_busy, m_done, 4'(m_addr)};
    endfunction

    task automatic model_reset();
        m_busy = 1'b0; m_done = 1'b0; m_addr = 0; m_pos = 0; m_stop = 1'b0;
    endtask

    task automatic model_edge(input logic st, input logic sp, input logic lp, input logic mf,
                              input logic [3:0] la, input logic we, input logic [3:0] wa,
                              input logic [7:0] wd);
        m_done = 1'b0;
        if (!m_busy) begin
            if (st) begin
                m_busy = 1'b1; m_addr = 0; m_pos = 0; m_word = m_mem[0];
                m_loop = lp; m_msb = mf; m_last = (int'(la) > D - 1) ? D - 1 : int'(la);
                m_stop = 1'b0;
            end
        end else begin
            if (sp) m_stop = 1'b1;
            if (m_pos == Period - 1) begin
                if (m_stop || (m_addr == m_last && !m_loop)) begin
                    m_busy = 1'b0; m_done = 1'b1;
                end else begin
                    m_addr = (m_addr == m_last) ? 0 : m_addr + 1;
                    m_word = m_mem[m_addr];
                    m_pos  = 0;
                end
            end else begin
                m_pos++;
            end
        end
        if (we && int'(wa) < D) m_mem[wa] = wd;
    endtask

    task automatic tick(input logic st, input logic sp, input logic lp, input logic mf,
                        input logic [3:0] la, input logic we, input logic [3:0] wa,
                        input logic [7:0] wd);
        start = st; stop = sp; loop = lp; msb_first = mf; last_addr = la;
        wr_en = we; wr_addr = wa; wr_data = wd;
        @(posedge clk);
        if (clear_n) model_edge(st, sp, lp, mf, la, we, wa, wd);
        #1;
    endtask

    task automatic idle();
        tick(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 8'h00);
    endtask

    task automatic test_reset();
        clear_n = 1'b0;
        start = 0; stop = 0; loop = 0; msb_first = 0; last_addr = 0;
        wr_en = 0; wr_addr = 0; wr_data = 0;
        model_reset();
        #12;
        n_tests++;
        if ({sout, valid, busy, done, cur_addr} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset: got %b want %b", {sout, valid, busy, done, cur_addr}, 8'h00);
        end
        @(posedge clk); #1;
        clear_n = 1'b1;
        for (int a = 0; a < D; a++) begin
            tick(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, a[3:0], (a % 2 == 1) ? 8'hAA : 8'hCC);
            n_tests++;
            if ({sout, valid, busy, done, cur_addr} !== exp_vec()) begin
                n_fail++;
                $display("FAIL idle_init a=%0d: got %b want %b", a,
                         {sout, valid, busy, done, cur_addr}, exp_vec());
            end
        end
    endtask

    task automatic test_one_shot();
        logic [17:0] bits = '0;
        int nv = 0, nd = 0;
        tick(1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0, 4'd0, 8'h00);
        for (int c = 0; c < 2 * Period + 3; c++) begin
            n_tests++;
            if ({sout, valid, busy, done, cur_addr} !== exp_vec()) begin
                n_fail++;
                $display("FAIL one_shot c=%0d: got %b want %b", c,
                         {sout, valid, busy, done, cur_addr}, exp_vec());
            end
            if (valid) begin bits = {bits[16:0], sout}; nv++; end
            if (done) nd++;
            idle();
        end
        n_tests++;
        if (nv != 2 * Period || nd != 1) begin
            n_fail++;
            $display("FAIL one_shot_count: got bits=%0d done=%0d want %0d/1", nv, nd, 2 * Period);
        end
        n_tests++;
`ifdef SER_PARITY_EN
        if (bits !== 18'b110011000_101010100) begin
`else
        if (bits[15:0] !== 16'hCCAA) begin
`endif
            n_fail++;
            $display("FAIL one_shot_bits: got %b", bits);
        end
    endtask

    task automatic test_lsb();
        logic [8:0] bits = '0;
        int nd = 0;
        tick(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 8'h00);
        for (int c = 0; c < Period + 3; c++) begin
            n_tests++;
            if ({sout, valid, busy, done, cur_addr} !== exp_vec()) begin
                n_fail++;
                $display("FAIL lsb c=%0d: got %b want %b", c,
                         {sout, valid, busy, done, cur_addr}, exp_vec());
            end
            if (valid) bits = {bits[7:0], sout};
            if (done) nd++;
            idle();
        end
        n_tests++;
`ifdef SER_PARITY_EN
        if (bits !== 9'b001100110 || nd != 1) begin
`else
        if (bits[7:0] !== 8'b00110011 || nd != 1) begin
`endif
            n_fail++;
            $display("FAIL lsb_bits: got %b done=%0d", bits, nd);
        end
    endtask

    task automatic test_loop_stop();
        int nv = 0, nd = 0;
        int addrs[$];
        tick(1'b1, 1'b0, 1'b1, 1'b1, 4'd1, 1'b0, 4'd0, 8'h00);
        for (int c = 0; c < 40; c++) begin
            n_tests++;
            if ({sout, valid, busy, done, cur_addr} !== exp_vec()) begin
                n_fail++;
                $display("FAIL loop_stop c=%0d: got %b want %b", c,
                         {sout, valid, busy, done, cur_addr}, exp_vec());
            end
            if (valid) begin
                nv++;
                if ((nv - 1) % Period == 0) addrs.push_back(int'(cur_addr));
            end
            if (done) nd++;
            tick(1'b0, valid && (nv == 20), 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 8'h00);
        end
        n_tests++;
        if (nv != 3 * Period || nd != 1) begin
            n_fail++;
            $display("FAIL loop_stop_count: got bits=%0d done=%0d want %0d/1", nv, nd, 3 * Period);
        end
        n_tests++;
        if (addrs.size() != 3 || addrs[0] != 0 || addrs[1] != 1 || addrs[2] != 0) begin
            n_fail++;
            $display("FAIL loop_addrs: got %p want 0,1,0", addrs);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] bits = '0;
        int nd = 0;
        tick(1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0, 4'd0, 8'h00);
        idle();
        idle();
        clear_n = 1'b0;
        #1;
        model_reset();
        n_tests++;
        if ({sout, valid, busy, done, cur_addr} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_mid: got %b want 00000000", {sout, valid, busy, done, cur_addr});
        end
        idle();
        n_tests++;
        if ({sout, valid, busy, done, cur_addr} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_hold: got %b want 00000000", {sout, valid, busy, done, cur_addr});
        end
        clear_n = 1'b1;
        tick(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 4'd0, 8'h00);
        for (int c = 0; c < Period + 2; c++) begin
            n_tests++;
            if ({sout, valid, busy, done, cur_addr} !== exp_vec()) begin
                n_fail++;
                $display("FAIL replay c=%0d: got %b want %b", c,
                         {sout, valid, busy, done, cur_addr}, exp_vec());
            end
            if (valid && c < W) bits = {bits[6:0], sout};
            if (done) nd++;
            idle();
        end
        n_tests++;
        if (bits !== 8'hCC || nd != 1) begin
            n_fail++;
            $display("FAIL replay_bits: got %h done=%0d want cc/1", bits, nd);
        end
    endtask

    task automatic test_busy_write();
        logic [17:0] bits = '0;
        int nv = 0, nd = 0;
        tick(1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0, 4'd0, 8'h00);
        for (int c = 0; c < 3 * Period; c++) begin
            n_tests++;
            if ({sout, valid, busy, done, cur_addr} !== exp_vec()) begin
                n_fail++;
                $display("FAIL busy_write c=%0d: got %b want %b", c,
                         {sout, valid, busy, done, cur_addr}, exp_vec());
            end
            if (valid) begin bits = {bits[16:0], sout}; nv++; end
            if (done) nd++;
            if (c == 0) tick(1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 1'b1, 4'd1, 8'hF0);
            else        idle();
        end
        n_tests++;
`ifdef SER_PARITY_EN
        if (bits !== 18'b110011000_111100000 || nv != 2 * Period || nd != 1) begin
`else
        if (bits[15:0] !== 16'hCCF0 || nv != 2 * Period || nd != 1) begin
`endif
            n_fail++;
            $display("FAIL busy_write_bits: got %b bits=%0d done=%0d", bits, nv, nd);
        end
        tick(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 4'd1, 8'hAA);
    endtask

    task automatic test_parity();
        logic [17:0] bits = '0;
        tick(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 4'd1, 8'hAB);
        tick(1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0, 4'd0, 8'h00);
        for (int c = 0; c < 2 * Period + 3; c++) begin
            n_tests++;
            if ({sout, valid, busy, done, cur_addr} !== exp_vec()) begin
                n_fail++;
                $display("FAIL parity c=%0d: got %b want %b", c,
                         {sout, valid, busy, done, cur_addr}, exp_vec());
            end
            if (valid) bits = {bits[16:0], sout};
            idle();
        end
        n_tests++;
`ifdef SER_PARITY_EN
        if (bits !== 18'b110011000_101010111) begin
`else
        if (bits[15:0] !== 16'hCCAB) begin
`endif
            n_fail++;
            $display("FAIL parity_bits: got %b", bits);
        end
        tick(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 4'd1, 8'hAA);
    endtask

    task automatic test_random();
        logic st, sp, lp, mf, we;
        logic [3:0] la, wa;
        logic [7:0] wd;
        for (int it = 0; it < 8; it++) begin
            lp = 1'($urandom_range(0, 1));
            mf = 1'($urandom_range(0, 1));
            la = 4'($urandom_range(0, 15));
            tick(1'b1, 1'b0, lp, mf, la, 1'b0, 4'd0, 8'h00);
            for (int c = 0; c < 60 + 2 * Period; c++) begin
                n_tests++;
                if ({sout, valid, busy, done, cur_addr} !== exp_vec()) begin
                    n_fail++;
                    $display("FAIL random it=%0d c=%0d: got %b want %b", it, c,
                             {sout, valid, busy, done, cur_addr}, exp_vec());
                end
                we = ($urandom_range(0, 3) == 0);
                wa = 4'($urandom_range(0, 15));
                wd = 8'($urandom);
                sp = (c == 40) || ($urandom_range(0, 50) == 0);
                st = (c < 40) && ($urandom_range(0, 7) == 0);
                tick(st, sp, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     4'($urandom_range(0, 15)), we, wa, wd);
            end
        end
    endtask

    initial begin
        test_reset();
        test_one_shot();
        test_lsb();
        test_loop_stop();
        test_reset_mid();
        test_busy_write();
        test_parity();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
